// File: rtl/proc_pkg.sv
// proc_pkg: shared widths and fetch state encoding for the front end.
package proc_pkg;
    localparam int INSTR_W  = 32;
    localparam int ADDR_W   = 64;
    localparam int BR_SHIFT = 2;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_DROP} fetch_state_e;
endpackage

// File: rtl/branch_target_adder.sv
// branch_target_adder: br_pc + (word offset << BR_SHIFT), wrapping modulo 2^ADDR_W.
module branch_target_adder
    import proc_pkg::*;
(
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] imm_i,
    output logic [ADDR_W-1:0] target_o
);
    // The shift drops imm_i's top bits, so negative offsets stay correct by wrap.
    assign target_o = pc_i + {imm_i[ADDR_W-BR_SHIFT-1:0], {BR_SHIFT{1'b0}}};
endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: owns the PC, issues one imem request at a time and
// hands fetched words to decode; taken branches redirect and squash in-flight work.
module fetch_redirect_unit
    import proc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = 64'd4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_out_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    input  logic               br_resolve_i,
    input  logic               br_taken_i,
    input  logic [ADDR_W-1:0]  br_pc_i,
    input  logic [ADDR_W-1:0]  br_imm_i,
    output logic               redirect_o
);
    fetch_state_e       state_q;
    logic [ADDR_W-1:0]  pc_q, addr_q, ipc_q, target;
    logic [INSTR_W-1:0] instr_q;
    logic               req_q, valid_q, redirect_q;
    logic               taken;

    branch_target_adder u_bta (.pc_i(br_pc_i), .imm_i(br_imm_i), .target_o(target));

    assign taken = br_resolve_i & br_taken_i;

    // addr_q is separate from pc_q so S_DROP can keep the old request address
    // on the bus while pc_q already holds the redirect target.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            ipc_q      <= '0;
            redirect_q <= 1'b0;
        end else begin
            redirect_q <= taken;
            if (taken) pc_q <= target;
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                    addr_q  <= taken ? target : pc_q;
                end
                S_REQ: begin
                    if (taken) begin
                        if (imem_ack_i) addr_q <= target;
                        else state_q <= S_DROP;
                    end else if (imem_ack_i) begin
                        state_q <= S_VALID;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        instr_q <= imem_rdata_i;
                        ipc_q   <= pc_q;
                    end
                end
                S_VALID: begin
                    if (taken || instr_ready_i) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                        addr_q  <= taken ? target : pc_q + PC_STEP;
                        if (!taken) pc_q <= pc_q + PC_STEP;
                    end
                end
                S_DROP: begin
                    if (imem_ack_i) begin
                        state_q <= S_REQ;
                        addr_q  <= taken ? target : pc_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = valid_q;
    assign instr_out_o   = instr_q;
    assign instr_pc_o    = ipc_q;
    assign redirect_o    = redirect_q;
endmodule
